demux1x8_tdm: RTL and testbench

DEMUX1X8_TDM -- requirements
Module: demux1x8_tdm

---
 rtl/demux1x8_tdm.sv | 115 +++++++++++
 tb/tb_demux1x8_tdm.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/demux1x8_tdm.sv
// demux1x8_tdm: 1-to-8 serial TDM demultiplexer with per-slot latches and atomic frame capture.
// Define DEMUX1X8_PARITY_EN to add a ninth slot carrying even parity over slots 0..7.
module demux1x8_tdm (
   input  logic       clk,
   input  logic       rst,
   input  logic       din,
   input  logic       en,
   input  logic       sync,
   output logic [7:0] y,
   output logic [7:0] frame,
   output logic       frame_valid,
   output logic [3:0] slot,
   output logic       locked,
   output logic       sync_err,
   output logic       parity_err
);

`ifdef DEMUX1X8_PARITY_EN
   localparam logic [3:0] LAST_SLOT = 4'd8;

   function automatic logic even_parity_ok(input logic [8:0] bits);
      return ~(^bits);
   endfunction

   logic parity_err_s;
`else
   localparam logic [3:0] LAST_SLOT = 4'd7;
`endif

   logic [7:0] y_s;
   logic [7:0] frame_s;
   logic       frame_valid_s;
   logic [3:0] slot_s;
   logic       locked_s;
   logic       sync_err_s;

   // Next-state decode: slot sequencing, sync alignment and end-of-frame handling.
   always_comb begin
      y_s           = y;
      frame_s       = frame;
      frame_valid_s = 1'b0;
      slot_s        = slot;
      locked_s      = locked;
      sync_err_s    = 1'b0;
`ifdef DEMUX1X8_PARITY_EN
      parity_err_s  = 1'b0;
`endif
      if (!en) begin
      end else if (!locked) begin
         if (sync) begin
            y_s[0]   = din;
            slot_s   = 4'd1;
            locked_s = 1'b1;
         end else begin
         end
      end else if (sync && (slot != 4'd0)) begin
         // Misaligned sync restarts the frame; the partial frame is dropped.
         sync_err_s = 1'b1;
         y_s[0]     = din;
         slot_s     = 4'd1;
      end else if (slot < LAST_SLOT) begin
         y_s[slot[2:0]] = din;
         slot_s         = slot + 4'd1;
      end else if (slot == LAST_SLOT) begin
`ifdef DEMUX1X8_PARITY_EN
         if (even_parity_ok({din, y})) begin
            frame_s       = y;
            frame_valid_s = 1'b1;
         end else begin
            parity_err_s  = 1'b1;
         end
`else
         y_s[7]        = din;
         frame_s       = {din, y[6:0]};
         frame_valid_s = 1'b1;
`endif
         slot_s = 4'd0;
      end else begin
         slot_s = 4'd0;
      end
   end

   // Output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         y           <= 8'd0;
         frame       <= 8'd0;
         frame_valid <= 1'b0;
         slot        <= 4'd0;
         locked      <= 1'b0;
         sync_err    <= 1'b0;
      end else begin
         y           <= y_s;
         frame       <= frame_s;
         frame_valid <= frame_valid_s;
         slot        <= slot_s;
         locked      <= locked_s;
         sync_err    <= sync_err_s;
      end
   end

`ifdef DEMUX1X8_PARITY_EN
   // Parity error pulse register.
   always_ff @(posedge clk) begin
      if (rst) begin
         parity_err <= 1'b0;
      end else begin
         parity_err <= parity_err_s;
      end
   end
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_demux1x8_tdm.sv
// Self-checking bench for demux1x8_tdm: queue-based frame model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_demux1x8_tdm;

`ifdef DEMUX1X8_PARITY_EN
   localparam int NS = 9;
`else
   localparam int NS = 8;
`endif

   logic       clk = 1'b0;
   logic       rst, din, en, sync;
   logic [7:0] y, frame;
   logic       frame_valid, locked, sync_err, parity_err;
   logic [3:0] slot;

   demux1x8_tdm dut (
      .clk(clk), .rst(rst), .din(din), .en(en), .sync(sync),
      .y(y), .frame(frame), .frame_valid(frame_valid), .slot(slot),
      .locked(locked), .sync_err(sync_err), .parity_err(parity_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   bit check_on = 1'b0;

   // Behavioural model: samples of the frame in progress are kept in a queue.
   bit         m_locked;
   logic [7:0] m_y, m_frame;
   bit         m_fv, m_se, m_pe;
   bit         q[$];

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic void model_step();
      int ones;
      m_fv = 1'b0; m_se = 1'b0; m_pe = 1'b0;
      if (rst) begin
         m_locked = 1'b0; m_y = 8'h00; m_frame = 8'h00; q.delete();
      end else if (en) begin
         if (!m_locked) begin
            if (sync) begin
               m_locked = 1'b1; q.delete(); q.push_back(din); m_y[0] = din;
            end
         end else if (sync && q.size() != 0) begin
            m_se = 1'b1; q.delete(); q.push_back(din); m_y[0] = din;
         end else begin
            if (q.size() < 8) m_y[q.size()] = din;
            q.push_back(din);
            if (q.size() == NS) begin
               ones = 0;
               foreach (q[i]) ones += int'(q[i]);
`ifdef DEMUX1X8_PARITY_EN
               if (ones % 2 == 0) begin
                  for (int k = 0; k < 8; k++) m_frame[k] = q[k];
                  m_fv = 1'b1;
               end else begin
                  m_pe = 1'b1;
               end
`else
               for (int k = 0; k < 8; k++) m_frame[k] = q[k];
               m_fv = 1'b1;
`endif
               q.delete();
            end
         end
      end
   endfunction

   // Compare process: inputs still hold the values sampled at the preceding rising edge.
   initial begin
      forever begin
         @(negedge clk);
         if (check_on) begin
            model_step();
            check("y", 32'(y), 32'(m_y));
            check("frame", 32'(frame), 32'(m_frame));
            check("frame_valid", 32'(frame_valid), 32'(m_fv));
            check("slot", 32'(slot), m_locked ? 32'(q.size()) : 32'd0);
            check("locked", 32'(locked), 32'(m_locked));
            check("sync_err", 32'(sync_err), 32'(m_se));
            check("parity_err", 32'(parity_err), 32'(m_pe));
         end
      end
   end

   task automatic tick(input logic r, input logic e, input logic s, input logic d);
      rst = r; en = e; sync = s; din = d;
      @(negedge clk);
      #1;
   endtask

   function automatic logic [8:0] with_par(input logic [7:0] d, input logic flip);
      return {(^d) ^ flip, d};
   endfunction

   // Sends bits[from..to-1]; sync on the first one if requested, optional idle gaps between.
   task automatic send(input logic [8:0] bits, input int from, input int to,
                       input bit first_sync, input bit gaps);
      for (int i = from; i < to; i++) begin
         tick(1'b0, 1'b1, first_sync && (i == from), bits[i]);
         if (gaps && i != to - 1) tick(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      bit r, e, s;
      check_on = 1'b1;
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 1'b1, 1'b1);
      check("rst_locked", 32'(locked), 32'd0);
      check("rst_slot", 32'(slot), 32'd0);
      check("rst_y", 32'(y), 32'd0);
      check("rst_frame", 32'(frame), 32'd0);

      repeat (5) tick(1'b0, 1'b1, 1'b0, 1'b1);
      check("nosync_locked", 32'(locked), 32'd0);
      check("nosync_slot", 32'(slot), 32'd0);
      check("nosync_y", 32'(y), 32'd0);

      send(with_par(8'h65, 1'b0), 0, NS, 1'b1, 1'b0);
      check("f65_frame", 32'(frame), 32'h65);
      check("f65_fv", 32'(frame_valid), 32'd1);
      check("f65_slot", 32'(slot), 32'd0);
      check("model_f65", 32'(m_frame), 32'h65);
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      check("f65_fv_gone", 32'(frame_valid), 32'd0);

      send(with_par(8'h00, 1'b0), 0, NS, 1'b1, 1'b0);
      check("f00_frame", 32'(frame), 32'h00);
      send(with_par(8'h65, 1'b0), 0, NS, 1'b1, 1'b1);
      check("gap_frame", 32'(frame), 32'h65);
      check("gap_fv", 32'(frame_valid), 32'd1);

      send(with_par(8'h65, 1'b0), 0, 4, 1'b1, 1'b0);
      tick(1'b0, 1'b1, 1'b1, 1'b0);
      check("serr_pulse", 32'(sync_err), 32'd1);
      check("serr_slot", 32'(slot), 32'd1);
      check("serr_fv", 32'(frame_valid), 32'd0);
      send(with_par(8'h5A, 1'b0), 1, NS, 1'b0, 1'b0);
      check("after_serr_frame", 32'(frame), 32'h5A);
      check("after_serr_fv", 32'(frame_valid), 32'd1);
      check("after_serr_se", 32'(sync_err), 32'd0);

      send(with_par(8'h65, 1'b0), 0, 7, 1'b1, 1'b0);
      tick(1'b0, 1'b1, 1'b1, 1'b1);
      check("s7sync_se", 32'(sync_err), 32'd1);
      check("s7sync_fv", 32'(frame_valid), 32'd0);
      check("s7sync_frame", 32'(frame), 32'h5A);

`ifdef DEMUX1X8_PARITY_EN
      send(with_par(8'h5A, 1'b0), 0, NS, 1'b1, 1'b0);
      send(with_par(8'h65, 1'b0), 0, NS, 1'b1, 1'b0);
      check("par_ok_frame", 32'(frame), 32'h65);
      check("par_ok_fv", 32'(frame_valid), 32'd1);
      send(with_par(8'h5A, 1'b0), 0, NS, 1'b1, 1'b0);
      send(with_par(8'h65, 1'b1), 0, NS, 1'b1, 1'b0);
      check("par_bad_pe", 32'(parity_err), 32'd1);
      check("par_bad_fv", 32'(frame_valid), 32'd0);
      check("par_bad_frame", 32'(frame), 32'h5A);
`endif

      send(with_par(8'h65, 1'b0), 0, 5, 1'b1, 1'b0);
      check("mid_slot", 32'(slot), 32'd5);
      tick(1'b1, 1'b1, 1'b0, 1'b1);
      check("mid_rst_y", 32'(y), 32'd0);
      check("mid_rst_frame", 32'(frame), 32'd0);
      check("mid_rst_slot", 32'(slot), 32'd0);
      check("mid_rst_locked", 32'(locked), 32'd0);
      repeat (3) tick(1'b0, 1'b1, 1'b0, 1'b1);
      check("post_rst_locked", 32'(locked), 32'd0);
      check("post_rst_y", 32'(y), 32'd0);

      for (int c = 0; c < 3000; c++) begin
         r = ($urandom_range(0, 249) == 0);
         e = ($urandom_range(0, 3) != 0);
         if (!m_locked)          s = ($urandom_range(0, 3) == 0);
         else if (q.size() == 0) s = ($urandom_range(0, 1) == 0);
         else                    s = ($urandom_range(0, 29) == 0);
         tick(r, e, s, 1'($urandom_range(0, 1)));
      end

      check_on = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
